// File: rtl/accel_ctrl_pkg.sv
// Shared types and default sizing for the inference job controller.
package accel_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEND = 2'd2
  } ctrl_state_t;

  localparam int IP_ADDR_WIDTH_DEF  = 32;
  localparam int MAC_ADDR_WIDTH_DEF = 48;
  localparam int RESULT_WIDTH_DEF   = 8;
  localparam int COUNTER_WIDTH_DEF  = 16;
  localparam int TIMEOUT_WIDTH_DEF  = 24;
  localparam int TIMEOUT_CYCLES_DEF = 1000000;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/inference_job_ctrl.sv
// Runs one accelerator job per received frame and hands the result and
// the requester's return address to the transmit path.
//
// state | meaning
// IDLE  | waiting for a frame addressed to the accelerator
// RUN   | core started, frame locked, watchdog running
// SEND  | result offered to transmit path, held until accepted
module inference_job_ctrl
  import accel_ctrl_pkg::*;
#(
  parameter int IP_ADDR_WIDTH  = IP_ADDR_WIDTH_DEF,
  parameter int MAC_ADDR_WIDTH = MAC_ADDR_WIDTH_DEF,
  parameter int RESULT_WIDTH   = RESULT_WIDTH_DEF,
  parameter int COUNTER_WIDTH  = COUNTER_WIDTH_DEF,
  parameter int TIMEOUT_WIDTH  = TIMEOUT_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      FRAME_READY,
  input  logic                      PACKET_FOR_ACCELERATOR,
  input  logic [IP_ADDR_WIDTH-1:0]  SRC_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0] SRC_MAC_ADDRESS,
  output logic                      FRAME_LOCK,
  output logic                      CORE_START,
  input  logic                      CORE_DONE,
  input  logic [RESULT_WIDTH-1:0]   CORE_RESULT,
  output logic                      CORE_ABORT,
  output logic                      TX_VALID,
  input  logic                      TX_READY,
  output logic [RESULT_WIDTH-1:0]   TX_RESULT,
  output logic [IP_ADDR_WIDTH-1:0]  TX_DST_IP,
  output logic [MAC_ADDR_WIDTH-1:0] TX_DST_MAC,
  output logic                      BUSY,
  output logic [COUNTER_WIDTH-1:0]  FRAMES_ACCEPTED,
  output logic [COUNTER_WIDTH-1:0]  FRAMES_DROPPED,
  output logic [COUNTER_WIDTH-1:0]  TIMEOUTS
);

  ctrl_state_t              state, state_nxt;
  logic                     frame_ready_q;
  logic                     frame_valid;
  logic [TIMEOUT_WIDTH-1:0] wd;
  logic                     wd_expired;
  logic                     accept, drop, done_hit, timeout_hit;

  assign frame_valid = FRAME_READY & ~frame_ready_q & PACKET_FOR_ACCELERATOR;
  // Watchdog holds at 0 through the start-pulse cycle, then counts run cycles.
  assign wd_expired  = (state == RUN) && !CORE_START &&
                       (wd == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign BUSY        = (state != IDLE);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_valid) state_nxt = RUN;
      RUN: begin
        if (CORE_DONE)       state_nxt = SEND;
        else if (wd_expired) state_nxt = IDLE;
      end
      SEND:    if (TX_VALID && TX_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept      = (state == IDLE) && frame_valid;
    drop        = (state != IDLE) && frame_valid;
    done_hit    = (state == RUN) && CORE_DONE;
    timeout_hit = (state == RUN) && !CORE_DONE && wd_expired;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      frame_ready_q <= 1'b0;
      CORE_START    <= 1'b0;
      CORE_ABORT    <= 1'b0;
      FRAME_LOCK    <= 1'b0;
      TX_VALID      <= 1'b0;
      TX_RESULT     <= '0;
      TX_DST_IP     <= '0;
      TX_DST_MAC    <= '0;
      wd            <= '0;
    end else begin
      frame_ready_q <= FRAME_READY;
      CORE_START    <= accept;
      CORE_ABORT    <= timeout_hit;
      FRAME_LOCK    <= (state_nxt == RUN);
      TX_VALID      <= (state_nxt == SEND);
      wd            <= ((state == RUN) && !CORE_START) ? wd + TIMEOUT_WIDTH'(1) : '0;
      if (accept) begin
        TX_DST_IP  <= SRC_IP_ADDRESS;
        TX_DST_MAC <= SRC_MAC_ADDRESS;
      end
      if (done_hit) TX_RESULT <= CORE_RESULT;
    end
  end

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_accepted (
    .clk(ACLK), .rst(ARESET), .inc(accept), .count(FRAMES_ACCEPTED)
  );

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_dropped (
    .clk(ACLK), .rst(ARESET), .inc(drop), .count(FRAMES_DROPPED)
  );

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_timeouts (
    .clk(ACLK), .rst(ARESET), .inc(timeout_hit), .count(TIMEOUTS)
  );

endmodule

// File: tb/tb_inference_job_ctrl.sv
// Self-checking bench: vector table, directed corner cases and random traffic
// against a job-level reference model.
module tb_inference_job_ctrl;

  localparam int T    = 100;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        FRAME_READY, PACKET_FOR_ACCELERATOR;
  logic [31:0] SRC_IP_ADDRESS;
  logic [47:0] SRC_MAC_ADDRESS;
  logic        FRAME_LOCK, CORE_START, CORE_DONE, CORE_ABORT;
  logic [7:0]  CORE_RESULT, TX_RESULT;
  logic        TX_VALID, TX_READY, BUSY;
  logic [31:0] TX_DST_IP;
  logic [47:0] TX_DST_MAC;
  logic [CW-1:0] FRAMES_ACCEPTED, FRAMES_DROPPED, TIMEOUTS;

  inference_job_ctrl #(
    .COUNTER_WIDTH(CW), .TIMEOUT_CYCLES(T)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .FRAME_READY(FRAME_READY),
    .PACKET_FOR_ACCELERATOR(PACKET_FOR_ACCELERATOR),
    .SRC_IP_ADDRESS(SRC_IP_ADDRESS), .SRC_MAC_ADDRESS(SRC_MAC_ADDRESS),
    .FRAME_LOCK(FRAME_LOCK), .CORE_START(CORE_START), .CORE_DONE(CORE_DONE),
    .CORE_RESULT(CORE_RESULT), .CORE_ABORT(CORE_ABORT), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .TX_RESULT(TX_RESULT), .TX_DST_IP(TX_DST_IP),
    .TX_DST_MAC(TX_DST_MAC), .BUSY(BUSY), .FRAMES_ACCEPTED(FRAMES_ACCEPTED),
    .FRAMES_DROPPED(FRAMES_DROPPED), .TIMEOUTS(TIMEOUTS)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  // Reference model: a job is either in flight at the core or waiting for tx.
  bit          m_prev_fr, m_in_flight, m_pending, m_start, m_abort;
  int          m_age, m_acc, m_drop, m_to;
  logic [7:0]  m_result;
  logic [31:0] m_ip;
  logic [47:0] m_mac;

  typedef struct packed {
    bit fr, pfa, done, txr;
    bit e_start, e_lock, e_valid, e_busy;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_fr = 0; m_in_flight = 0; m_pending = 0; m_start = 0; m_abort = 0;
    m_age = 0; m_acc = 0; m_drop = 0; m_to = 0;
    m_result = '0; m_ip = '0; m_mac = '0;
  endtask

  task automatic model_update();
    bit nf;
    nf = FRAME_READY && !m_prev_fr && PACKET_FOR_ACCELERATOR;
    m_prev_fr = FRAME_READY;
    m_start = 0;
    m_abort = 0;
    if (!m_in_flight && !m_pending) begin
      if (nf) begin
        m_ip = SRC_IP_ADDRESS; m_mac = SRC_MAC_ADDRESS;
        m_start = 1; m_in_flight = 1; m_age = 0;
        if (m_acc < CMAX) m_acc++;
      end
    end else begin
      if (nf && m_drop < CMAX) m_drop++;
      if (m_in_flight) begin
        if (CORE_DONE) begin
          m_result = CORE_RESULT; m_in_flight = 0; m_pending = 1;
        end else if (m_age == T) begin
          // the core gets T full cycles after its start cycle
          m_abort = 1; m_in_flight = 0;
          if (m_to < CMAX) m_to++;
        end else begin
          m_age++;
        end
      end else if (TX_READY) begin
        m_pending = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("core_start", 64'(CORE_START), 64'(m_start));
    chk("core_abort", 64'(CORE_ABORT), 64'(m_abort));
    chk("frame_lock", 64'(FRAME_LOCK), 64'(m_in_flight));
    chk("tx_valid",   64'(TX_VALID),   64'(m_pending));
    chk("busy",       64'(BUSY),       64'(m_in_flight || m_pending));
    chk("tx_result",  64'(TX_RESULT),  64'(m_result));
    chk("tx_dst_ip",  64'(TX_DST_IP),  64'(m_ip));
    chk("tx_dst_mac", 64'(TX_DST_MAC), 64'(m_mac));
    chk("accepted",   64'(FRAMES_ACCEPTED), 64'(m_acc));
    chk("dropped",    64'(FRAMES_DROPPED),  64'(m_drop));
    chk("timeouts",   64'(TIMEOUTS),        64'(m_to));
  endtask

  task automatic step();
    model_update();
    @(posedge ACLK);
    #1;
    check_all();
  endtask

  initial begin
    int starts, ab_at, to_before, acc_before, drop_before;
    logic [7:0] held_res;

    ARESET = 1; FRAME_READY = 0; PACKET_FOR_ACCELERATOR = 0;
    SRC_IP_ADDRESS = '0; SRC_MAC_ADDRESS = '0;
    CORE_DONE = 0; CORE_RESULT = '0; TX_READY = 0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    check_all();
    ARESET = 0;

    // fr pfa done txr | start lock valid busy
    vecs[0] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1};
    vecs[1] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1};
    vecs[2] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1};
    vecs[3] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
    vecs[4] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0};
    vecs[5] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    vecs[7] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1};
    vecs[8] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1};
    vecs[9] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0};
    SRC_IP_ADDRESS = 32'h0a000001; SRC_MAC_ADDRESS = 48'h020000000001;
    CORE_RESULT = 8'h33;
    for (int i = 0; i < 10; i++) begin
      FRAME_READY = vecs[i].fr; PACKET_FOR_ACCELERATOR = vecs[i].pfa;
      CORE_DONE = vecs[i].done; TX_READY = vecs[i].txr;
      step();
      chk($sformatf("vec%0d_start", i), 64'(CORE_START), 64'(vecs[i].e_start));
      chk($sformatf("vec%0d_lock", i),  64'(FRAME_LOCK), 64'(vecs[i].e_lock));
      chk($sformatf("vec%0d_valid", i), 64'(TX_VALID),   64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_busy", i),  64'(BUSY),       64'(vecs[i].e_busy));
    end
    CORE_DONE = 0; TX_READY = 0; FRAME_READY = 0;
    step();

    // Happy path
    acc_before = m_acc;
    SRC_IP_ADDRESS = 32'hcccccccc; SRC_MAC_ADDRESS = 48'hdddddddddddd;
    PACKET_FOR_ACCELERATOR = 1; TX_READY = 1; FRAME_READY = 1;
    step();
    chk("hp_start", 64'(CORE_START), 64'd1);
    FRAME_READY = 0;
    repeat (49) step();
    CORE_DONE = 1; CORE_RESULT = 8'h07;
    step();
    CORE_DONE = 0;
    chk("hp_valid",  64'(TX_VALID),   64'd1);
    chk("hp_result", 64'(TX_RESULT),  64'h07);
    chk("hp_ip",     64'(TX_DST_IP),  64'hcccccccc);
    chk("hp_mac",    64'(TX_DST_MAC), 64'hdddddddddddd);
    step();
    chk("hp_valid_drop", 64'(TX_VALID), 64'd0);
    chk("hp_idle",       64'(BUSY),     64'd0);
    chk("hp_accepted",   64'(FRAMES_ACCEPTED), 64'(acc_before + 1));

    // Backpressure
    TX_READY = 0; FRAME_READY = 1;
    step();
    FRAME_READY = 0;
    repeat (3) step();
    CORE_DONE = 1; CORE_RESULT = 8'h5a;
    step();
    CORE_DONE = 0; CORE_RESULT = 8'hff;
    held_res = 8'h5a;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_valid",  64'(TX_VALID),  64'd1);
      chk("bp_result", 64'(TX_RESULT), 64'(held_res));
      chk("bp_ip",     64'(TX_DST_IP), 64'hcccccccc);
    end
    TX_READY = 1;
    step();
    chk("bp_idle", 64'(BUSY), 64'd0);

    // Drop while busy
    drop_before = m_drop; starts = 0;
    FRAME_READY = 1;
    step();
    starts += int'(CORE_START);
    FRAME_READY = 0;
    step();
    SRC_IP_ADDRESS = 32'h11111111; FRAME_READY = 1;
    step();
    starts += int'(CORE_START);
    chk("drop_count", 64'(FRAMES_DROPPED), 64'(drop_before + 1));
    chk("drop_ip",    64'(TX_DST_IP),      64'hcccccccc);
    FRAME_READY = 0; CORE_DONE = 1;
    step();
    starts += int'(CORE_START);
    CORE_DONE = 0;
    step();
    starts += int'(CORE_START);
    chk("drop_starts", 64'(starts), 64'd1);

    // Timeout
    to_before = m_to; ab_at = -1; TX_READY = 0;
    FRAME_READY = 1;
    step();
    FRAME_READY = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (TX_VALID) chk("to_no_valid", 64'(TX_VALID), 64'd0);
      if (CORE_ABORT) begin
        ab_at = k;
        break;
      end
    end
    chk("to_abort_cycle", 64'(ab_at), 64'(T + 1));
    chk("to_count", 64'(TIMEOUTS), 64'(to_before + 1));
    FRAME_READY = 1;
    step();
    chk("to_next_start", 64'(CORE_START), 64'd1);
    FRAME_READY = 0; CORE_DONE = 1;
    step();
    CORE_DONE = 0; TX_READY = 1;
    step();

    // DONE coinciding with the timeout cycle
    to_before = m_to;
    FRAME_READY = 1;
    step();
    FRAME_READY = 0; TX_READY = 0;
    repeat (T) step();
    CORE_DONE = 1; CORE_RESULT = 8'h42;
    step();
    CORE_DONE = 0;
    chk("co_no_abort", 64'(CORE_ABORT), 64'd0);
    chk("co_valid",    64'(TX_VALID),   64'd1);
    chk("co_timeouts", 64'(TIMEOUTS),   64'(to_before));
    TX_READY = 1;
    step();

    // Reset mid-RUN, then a frame not for us held across release
    FRAME_READY = 1;
    step();
    FRAME_READY = 0;
    repeat (5) step();
    ARESET = 1;
    #1;
    model_reset();
    check_all();
    chk("rst_lock", 64'(FRAME_LOCK), 64'd0);
    PACKET_FOR_ACCELERATOR = 0; FRAME_READY = 1;
    @(posedge ACLK);
    #1;
    check_all();
    ARESET = 0;
    repeat (4) begin
      step();
      chk("npf_start", 64'(CORE_START), 64'd0);
    end
    chk("npf_accepted", 64'(FRAMES_ACCEPTED), 64'd0);
    FRAME_READY = 0;
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) FRAME_READY = ~FRAME_READY;
      PACKET_FOR_ACCELERATOR = 1'($urandom);
      SRC_IP_ADDRESS  = $urandom;
      SRC_MAC_ADDRESS = {16'($urandom), 32'($urandom)};
      CORE_DONE   = ($urandom_range(0, 60) == 0);
      CORE_RESULT = 8'($urandom);
      TX_READY    = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inference_job_ctrl.md
Name: inference_job_ctrl

Overview:
- Sequences one inference job per received frame.
- Watches the IP receive block's frame-complete indication and locks its frame registers. Latches the requester's IP/MAC, starts the accelerator core, waits for its result, then hands the result and return address to the packet transmit path.
- Frames that arrive while a job is in flight are dropped and counted. A watchdog aborts hung core runs.

Parameters:
IP_ADDR_WIDTH, 32, IP address width
MAC_ADDR_WIDTH, 48, MAC address width
RESULT_WIDTH, 8, core result (class index) width
COUNTER_WIDTH, 16, width of statistics counters
TIMEOUT_WIDTH, 24, watchdog counter width
TIMEOUT_CYCLES, 1000000, max core run cycles before abort (>=2, < 2**TIMEOUT_WIDTH)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
FRAME_READY  in  1  receive block frame-complete (level; rising edge = new frame)
PACKET_FOR_ACCELERATOR  in  1  frame addressed to us; sampled with FRAME_READY rise
SRC_IP_ADDRESS  in  IP_ADDR_WIDTH  requester IP from receive block
SRC_MAC_ADDRESS  in  MAC_ADDR_WIDTH  requester MAC from receive block
FRAME_LOCK  out  1  high = receive block must hold DATA_FRAME stable
CORE_START  out  1  one-cycle start pulse to core
CORE_DONE  in  1  core finished (pulse or level; sampled in RUN only)
CORE_RESULT  in  RESULT_WIDTH  valid when CORE_DONE=1
CORE_ABORT  out  1  one-cycle abort pulse on timeout
TX_VALID  out  1  response request to transmit path
TX_READY  in  1  transmit path accepts
TX_RESULT  out  RESULT_WIDTH  latched result
TX_DST_IP  out  IP_ADDR_WIDTH  latched requester IP
TX_DST_MAC  out  MAC_ADDR_WIDTH  latched requester MAC
BUSY  out  1  state != IDLE
FRAMES_ACCEPTED  out  COUNTER_WIDTH  jobs started
FRAMES_DROPPED  out  COUNTER_WIDTH  valid frames ignored while busy
TIMEOUTS  out  COUNTER_WIDTH  aborted jobs

Behaviour:
- Reset: all outputs 0, state IDLE, latches 0, counters 0. Asserting ARESET mid-job returns to IDLE at once. No CORE_ABORT is issued; the core shares the reset.
- Edge detect: new_frame = FRAME_READY & ~frame_ready_q. frame_ready_q resets to 0.
  - A level held high across reset release counts as one new frame.
  - An edge with PACKET_FOR_ACCELERATOR=0 is ignored in all states and is not counted.
- IDLE, on valid new_frame:
  - Latch SRC_IP/SRC_MAC into TX_DST_IP/TX_DST_MAC.
  - Next cycle: CORE_START=1 for exactly one cycle, FRAME_LOCK=1, FRAMES_ACCEPTED+1.
  - Go to RUN.
  - Latency from FRAME_READY rise to CORE_START is 1 cycle (registered).
- RUN:
  - Watchdog counts from 0 starting the cycle after CORE_START.
  - CORE_DONE=1: latch CORE_RESULT into TX_RESULT, FRAME_LOCK=0, TX_VALID=1 next cycle, go to SEND.
  - Watchdog reaches TIMEOUT_CYCLES-1 with CORE_DONE=0: CORE_ABORT=1 one cycle, TIMEOUTS+1, FRAME_LOCK=0, go to IDLE.
  - CORE_DONE and timeout in the same cycle: DONE wins, no abort.
- SEND:
  - TX_VALID held high. TX_RESULT/TX_DST_* stay stable until accepted (AXI-style; must not change while TX_VALID=1 & TX_READY=0).
  - TX_VALID & TX_READY: TX_VALID=0 next cycle, go to IDLE.
  - A new frame is accepted no earlier than the cycle after the handshake.
- Drops: a valid new_frame in RUN or SEND increments FRAMES_DROPPED. Latches are untouched.
- Counters saturate at all-ones and do not wrap.
- FRAME_LOCK is high exactly from the CORE_START cycle until the cycle after DONE or abort.

Decomposition:
- Shared package accel_ctrl_pkg:
  - state enum ctrl_state_t {IDLE, RUN, SEND}
  - default widths and TIMEOUT_CYCLES constant.
- One sub-module, sat_counter (parameterised width, inc, saturate), instantiated three times for the statistics counters.

Test Plan:
- Happy path:
  - Stimulus: FRAME_READY rise, PACKET_FOR_ACCELERATOR=1, SRC_IP=32'hcccccccc, SRC_MAC=48'hdddddddddddd; CORE_DONE 50 cycles later with RESULT=8'h07; TX_READY=1.
  - Response: CORE_START one cycle after the edge. TX_VALID with RESULT 07, IP cccccccc, MAC dddddddddddd for 1 cycle. FRAMES_ACCEPTED=1, back to IDLE.
- Backpressure:
  - Stimulus: TX_READY held low 20 cycles.
  - Response: TX_VALID and TX_* stable for all 20 cycles; IDLE one cycle after TX_READY=1.
- Drop while busy:
  - Stimulus: second FRAME_READY edge during RUN with SRC_IP=32'h11111111.
  - Response: FRAMES_DROPPED=1, TX_DST_IP stays cccccccc, one CORE_START total.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100, no CORE_DONE.
  - Response: CORE_ABORT on run cycle 100, TIMEOUTS=1, TX_VALID never rises. The next frame is accepted normally.
- DONE/timeout coincidence:
  - Stimulus: CORE_DONE on the exact timeout cycle.
  - Response: no CORE_ABORT, SEND entered, TIMEOUTS unchanged.
- Reset mid-RUN and not-for-us:
  - Stimulus: ARESET pulse in RUN, then an edge with PACKET_FOR_ACCELERATOR=0.
  - Response: all outputs 0 immediately. No CORE_START; counters remain 0.
